// File: rtl/sl_pkg.sv
// Shared types and defaults for the SL link transmitter and receiver.
package sl_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} sl_state_e;
  typedef enum logic [1:0] {SYM0, SYM1, SYMSTOP} sl_sym_e;

  localparam int SL_PULSE_CLKS = 16;
  localparam int SL_GAP_CLKS   = 16;
  localparam int SL_MIN_LEN    = 8;
  localparam int SL_MAX_LEN    = 32;

  function automatic logic [31:0] len_mask(input logic [5:0] len);
    if (len >= 6'd32) return '1;
    else return (32'h1 << len) - 32'h1;
  endfunction

  // Symbol index 0..len-1 are data, len is parity, len+1 is stop.
  function automatic sl_sym_e sym_at(input logic [5:0] idx, input logic [5:0] len,
                                     input logic [31:0] data, input logic par);
    if (idx == len + 6'd1) return SYMSTOP;
    else if (idx == len) return par ? SYM1 : SYM0;
    else return data[idx[4:0]] ? SYM1 : SYM0;
  endfunction

  // Returns {sl1, sl0} for the low phase of a symbol.
  function automatic logic [1:0] sym_lines(input sl_sym_e s);
    case (s)
      SYM0:    return 2'b10;
      SYM1:    return 2'b01;
      SYMSTOP: return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/sl_sym_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module sl_sym_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - WIDTH'(1);
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sl_transmitter.sv
// SL link transmitter: serialises a word as data bits LSB first, parity, stop, idle gap.
module sl_transmitter
  import sl_pkg::*;
#(
  parameter int PULSE_CLKS = SL_PULSE_CLKS,
  parameter int GAP_CLKS   = SL_GAP_CLKS,
  parameter int MIN_LEN    = SL_MIN_LEN,
  parameter int MAX_LEN    = SL_MAX_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] tx_data,
  input  logic [5:0]  tx_len,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        sl0,
  output logic        sl1,
  output logic        busy,
  output logic        done,
  output logic        len_err
);

  localparam int MAX_CLKS = (PULSE_CLKS > GAP_CLKS) ? PULSE_CLKS : GAP_CLKS;
  localparam int TW       = (MAX_CLKS > 2) ? $clog2(MAX_CLKS) : 1;
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CLKS - 1);
  // The cycle that returns to IDLE counts as the last idle-high gap clock.
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CLKS - 2);

  sl_state_e   state, state_d;
  logic [5:0]  sym_cnt, sym_cnt_d;
  logic [5:0]  len_q, len_d;
  logic [31:0] data_q, data_d;
  logic        par_q, par_d;
  logic [1:0]  lines_d;
  logic        done_d, len_err_d;
  logic        load, tc;
  logic [TW-1:0] load_val;
  logic [31:0] masked_in;
  logic        par_in, len_ok;

  sl_sym_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sym_cnt <= '0;
      len_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      sl0     <= 1'b1;
      sl1     <= 1'b1;
      done    <= 1'b0;
      len_err <= 1'b0;
    end else begin
      state   <= state_d;
      sym_cnt <= sym_cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      par_q   <= par_d;
      sl1     <= lines_d[1];
      sl0     <= lines_d[0];
      done    <= done_d;
      len_err <= len_err_d;
    end
  end

  always_comb begin
    state_d   = state;
    sym_cnt_d = sym_cnt;
    len_d     = len_q;
    data_d    = data_q;
    par_d     = par_q;
    lines_d   = 2'b11;
    done_d    = 1'b0;
    len_err_d = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    masked_in = tx_data & len_mask(tx_len);
    par_in    = ~^masked_in;
    len_ok    = (tx_len >= 6'(MIN_LEN)) && (tx_len <= 6'(MAX_LEN));

    case (state)
      IDLE: begin
        if (tx_valid) begin
          if (len_ok) begin
            data_d    = masked_in;
            len_d     = tx_len;
            par_d     = par_in;
            sym_cnt_d = '0;
            load      = 1'b1;
            load_val  = PULSE_LOAD;
            lines_d   = sym_lines(sym_at(6'd0, tx_len, masked_in, par_in));
            state_d   = LOW;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      LOW: begin
        if (tc) begin
          load     = 1'b1;
          load_val = PULSE_LOAD;
          state_d  = HIGH;
        end else begin
          lines_d = sym_lines(sym_at(sym_cnt, len_q, data_q, par_q));
        end
      end
      HIGH: begin
        if (tc) begin
          load = 1'b1;
          if (sym_cnt == len_q + 6'd1) begin
            load_val = GAP_LOAD;
            state_d  = GAP;
          end else begin
            sym_cnt_d = sym_cnt + 6'd1;
            load_val  = PULSE_LOAD;
            lines_d   = sym_lines(sym_at(sym_cnt + 6'd1, len_q, data_q, par_q));
            state_d   = LOW;
          end
        end
      end
      GAP: begin
        if (tc) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule
